// File: rtl/sp_reader.sv
// Read-side sequencer for the result scratchpad: walks one stored matrix in
// row-major order and streams the returned elements through a 2-entry buffer.
module sp_reader #(
    parameter int SP_NTARGETS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 32,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int SPN_W      = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
    localparam int DIM_W      = $clog2(MAX_DIM) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [SPN_W-1:0]        sp_number_i,
    input  logic [DIM_W-1:0]        n_dim_i,
    input  logic [DIM_W-1:0]        k_dim_i,
    input  logic                    sp_write_busy_i,
    output logic                    sp_rd_en_o,
    output logic [ADDR_WIDTH-1:0]   sp_addr_o,
    input  logic [2*DATA_WIDTH-1:0] sp_data_i,
    output logic                    elem_valid_o,
    input  logic                    elem_ready_i,
    output logic [2*DATA_WIDTH-1:0] elem_data_o,
    output logic [DIM_W-1:0]        elem_row_o,
    output logic [DIM_W-1:0]        elem_col_o,
    output logic                    elem_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [DIM_W-1:0]      DIM_MAX  = DIM_W'(MAX_DIM);
    localparam logic [DIM_W-1:0]      DIM_ONE  = DIM_W'(1);
    localparam logic [DIM_W-1:0]      DIM_ZERO = DIM_W'(0);
    localparam logic [ADDR_WIDTH-1:0] SP_STRIDE  = ADDR_WIDTH'(MAX_DIM * MAX_DIM);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(MAX_DIM);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [SPN_W-1:0]        r_sp;
    logic [DIM_W-1:0]        r_n;
    logic [DIM_W-1:0]        r_k;
    logic [DIM_W-1:0]        r_row;
    logic [DIM_W-1:0]        r_col;
    logic                    r_err;

    logic [2*DATA_WIDTH-1:0] r_fifo_data [0:1];
    logic [DIM_W-1:0]        r_fifo_row  [0:1];
    logic [DIM_W-1:0]        r_fifo_col  [0:1];
    logic [1:0]              r_fifo_last;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;

    logic                    w_n_ok;
    logic                    w_k_ok;
    logic                    w_sp_ok;
    logic                    w_start_ok;
    logic                    w_start_bad;
    logic                    w_pop;
    logic                    w_space;
    logic                    w_rd_en;
    logic                    w_row_last;
    logic                    w_col_last;
    logic                    w_rd_last;
    logic [ADDR_WIDTH-1:0]   w_addr;

    assign w_n_ok      = (n_dim_i != DIM_ZERO) && (n_dim_i <= DIM_MAX);
    assign w_k_ok      = (k_dim_i != DIM_ZERO) && (k_dim_i <= DIM_MAX);
    assign w_sp_ok     = (32'(sp_number_i) < 32'(SP_NTARGETS));
    assign w_start_ok  = start_i && w_n_ok && w_k_ok && w_sp_ok;
    assign w_start_bad = start_i && !(w_n_ok && w_k_ok && w_sp_ok);

    // A full buffer still accepts a read when the head leaves in the same cycle.
    assign w_pop      = (r_count != 2'd0) && elem_ready_i;
    assign w_space    = (r_count < 2'd2) || w_pop;
    assign w_rd_en    = (r_state == S_READ) && !sp_write_busy_i && w_space;

    assign w_row_last = (r_row == (r_n - DIM_ONE));
    assign w_col_last = (r_col == (r_k - DIM_ONE));
    assign w_rd_last  = w_row_last && w_col_last;

    // Row stride is always MAX_DIM so every slot has a fixed footprint.
    assign w_addr = (ADDR_WIDTH'(r_sp) * SP_STRIDE)
                  + (ADDR_WIDTH'(r_row) * ROW_STRIDE)
                  + ADDR_WIDTH'(r_col);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (w_rd_en && w_rd_last) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_DRAIN: begin
                if (r_count == 2'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch and row/col walk.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sp  <= {SPN_W{1'b0}};
            r_n   <= DIM_ZERO;
            r_k   <= DIM_ZERO;
            r_row <= DIM_ZERO;
            r_col <= DIM_ZERO;
        end else if ((r_state == S_IDLE) && w_start_ok) begin
            r_sp  <= sp_number_i;
            r_n   <= n_dim_i;
            r_k   <= k_dim_i;
            r_row <= DIM_ZERO;
            r_col <= DIM_ZERO;
        end else if (w_rd_en) begin
            if (w_col_last) begin
                r_col <= DIM_ZERO;
                r_row <= r_row + DIM_ONE;
            end else begin
                r_col <= r_col + DIM_ONE;
            end
        end
    end

    // Illegal-command pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && w_start_bad;
        end
    end

    // Two-entry element buffer; storage is cleared on reset so outputs read 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= {(2*DATA_WIDTH){1'b0}};
                r_fifo_row[i]  <= DIM_ZERO;
                r_fifo_col[i]  <= DIM_ZERO;
            end
            r_fifo_last <= 2'b00;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_rd_en) begin
                r_fifo_data[r_wr_ptr] <= sp_data_i;
                r_fifo_row[r_wr_ptr]  <= r_row;
                r_fifo_col[r_wr_ptr]  <= r_col;
                r_fifo_last[r_wr_ptr] <= w_rd_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_rd_en, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign sp_rd_en_o   = w_rd_en;
    assign sp_addr_o    = w_rd_en ? w_addr : {ADDR_WIDTH{1'b0}};
    assign elem_valid_o = (r_count != 2'd0);
    assign elem_data_o  = r_fifo_data[r_rd_ptr];
    assign elem_row_o   = r_fifo_row[r_rd_ptr];
    assign elem_col_o   = r_fifo_col[r_rd_ptr];
    assign elem_last_o  = r_fifo_last[r_rd_ptr];
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign err_o        = r_err;

endmodule

// File: tb/tb_sp_reader.sv
// Scoreboard bench for sp_reader: expected addresses and elements are queued
// when a command is issued and compared as the DUT reads and emits them.
module tb_sp_reader;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } elem_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  sp_number_i;
    logic [1:0]  n_dim_i;
    logic [1:0]  k_dim_i;
    logic        sp_write_busy_i;
    logic        sp_rd_en_o;
    logic [31:0] sp_addr_o;
    logic [63:0] sp_data_i;
    logic        elem_valid_o;
    logic        elem_ready_i;
    logic [63:0] elem_data_o;
    logic [1:0]  elem_row_o;
    logic [1:0]  elem_col_o;
    logic        elem_last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int last_acc_cyc = 0;
    int first_rd_cyc = -1;
    int first_vld_cyc = -1;
    logic  hold_pending = 1'b0;
    elem_t held;
    elem_t exp_q[$];
    logic [31:0] exp_addr_q[$];

    function automatic logic [63:0] mem_val(input logic [31:0] a);
        return {16'hC0DE, a[15:0], 32'h9E37_79B9 ^ a};
    endfunction

    assign sp_data_i = mem_val(sp_addr_o);

    sp_reader dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .sp_number_i     (sp_number_i),
        .n_dim_i         (n_dim_i),
        .k_dim_i         (k_dim_i),
        .sp_write_busy_i (sp_write_busy_i),
        .sp_rd_en_o      (sp_rd_en_o),
        .sp_addr_o       (sp_addr_o),
        .sp_data_i       (sp_data_i),
        .elem_valid_o    (elem_valid_o),
        .elem_ready_i    (elem_ready_i),
        .elem_data_o     (elem_data_o),
        .elem_row_o      (elem_row_o),
        .elem_col_o      (elem_col_o),
        .elem_last_o     (elem_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: compares reads and accepted elements against the scoreboard.
    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_pending = 1'b0;
        end else begin
            if (sp_rd_en_o) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (sp_write_busy_i) check_eq("rd_while_wbusy", 64'd1, 64'd0);
                if (exp_addr_q.size() == 0) check_eq("unexpected_rd", 64'd1, 64'd0);
                else check_eq("rd_addr", 64'(sp_addr_o), 64'(exp_addr_q.pop_front()));
            end else begin
                check_eq("addr_idle_zero", 64'(sp_addr_o), 64'd0);
            end
            if (elem_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (hold_pending) begin
                check_eq("hold_valid", 64'(elem_valid_o), 64'd1);
                check_eq("hold_data", elem_data_o, held.data);
                check_eq("hold_rc", 64'({elem_row_o, elem_col_o, elem_last_o}),
                         64'({held.row, held.col, held.last}));
            end
            if (elem_valid_o && elem_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_elem", 64'd1, 64'd0);
                end else begin
                    elem_t e;
                    e = exp_q.pop_front();
                    check_eq("elem_data", elem_data_o, e.data);
                    check_eq("elem_row", 64'(elem_row_o), 64'(e.row));
                    check_eq("elem_col", 64'(elem_col_o), 64'(e.col));
                    check_eq("elem_last", 64'(elem_last_o), 64'(e.last));
                end
                if (elem_last_o) last_acc_cyc = cyc;
            end
            hold_pending = elem_valid_o && !elem_ready_i;
            held.data = elem_data_o;
            held.row  = elem_row_o;
            held.col  = elem_col_o;
            held.last = elem_last_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err_o) err_cnt++;
        end
    end

    task automatic do_start(input logic [1:0] sp, input logic [1:0] n, input logic [1:0] k);
        if (n >= 2'd1 && n <= 2'd2 && k >= 2'd1 && k <= 2'd2) begin
            for (int r = 0; r < int'(n); r++) begin
                for (int c = 0; c < int'(k); c++) begin
                    elem_t e;
                    logic [31:0] a;
                    a = 32'(int'(sp) * 4 + r * 2 + c);
                    e.data = mem_val(a);
                    e.row  = 2'(r);
                    e.col  = 2'(c);
                    e.last = (r == int'(n) - 1) && (c == int'(k) - 1);
                    exp_addr_q.push_back(a);
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk_i); #1;
        sp_number_i = sp;
        n_dim_i     = n;
        k_dim_i     = k;
        start_i     = 1'b1;
        @(posedge clk_i); #1;
        start_i     = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i); #1;
            if (done_cnt > d0) seen = 1'b1;
        end
        if (!seen) begin
            check_eq("done_timeout", 64'd0, 64'd1);
        end else begin
            check_eq("done_latency", 64'(done_cyc - last_acc_cyc), 64'd2);
            check_eq("done_count", 64'(done_cnt - d0), 64'd1);
            @(negedge clk_i); #1;
            check_eq("busy_after_done", 64'(busy_o), 64'd0);
            check_eq("done_one_cycle", 64'(done_o), 64'd0);
        end
        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check_eq("exp_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
    endtask

    task automatic check_all_zero();
        check_eq("rst_rd_en", 64'(sp_rd_en_o), 64'd0);
        check_eq("rst_addr", 64'(sp_addr_o), 64'd0);
        check_eq("rst_valid", 64'(elem_valid_o), 64'd0);
        check_eq("rst_data", elem_data_o, 64'd0);
        check_eq("rst_rc_last", 64'({elem_row_o, elem_col_o, elem_last_o}), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_err", 64'(err_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int e0;
        int dc;
        bit seen;
        rst_i = 1'b1;
        start_i = 1'b0;
        sp_number_i = 2'd0;
        n_dim_i = 2'd0;
        k_dim_i = 2'd0;
        sp_write_busy_i = 1'b0;
        elem_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero();
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Test 1: full-rate 2x2 read from slot 1
        base = rd_cnt;
        first_rd_cyc = -1;
        first_vld_cyc = -1;
        do_start(2'd1, 2'd2, 2'd2);
        check_eq("t1_busy", 64'(busy_o), 64'd1);
        wait_done();
        check_eq("t1_latency", 64'(first_vld_cyc - first_rd_cyc), 64'd1);
        check_eq("t1_reads", 64'(rd_cnt - base), 64'd4);

        // Test 2: 1x2 read from slot 3
        base = rd_cnt;
        do_start(2'd3, 2'd1, 2'd2);
        wait_done();
        check_eq("t2_reads", 64'(rd_cnt - base), 64'd2);

        // Test 3: downstream stalled, buffer fills after two reads
        base = rd_cnt;
        elem_ready_i = 1'b0;
        do_start(2'd1, 2'd2, 2'd2);
        repeat (8) @(posedge clk_i);
        #1;
        check_eq("t3_reads_stalled", 64'(rd_cnt - base), 64'd2);
        check_eq("t3_rd_en_low", 64'(sp_rd_en_o), 64'd0);
        check_eq("t3_valid", 64'(elem_valid_o), 64'd1);
        check_eq("t3_head_rc", 64'({elem_row_o, elem_col_o}), 64'd0);
        elem_ready_i = 1'b1;
        wait_done();
        check_eq("t3_reads", 64'(rd_cnt - base), 64'd4);

        // Test 4: write-busy stall for 3 cycles after the first read
        base = rd_cnt;
        do_start(2'd1, 2'd2, 2'd2);
        @(posedge clk_i); #1;
        sp_write_busy_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        sp_write_busy_i = 1'b0;
        wait_done();
        check_eq("t4_reads", 64'(rd_cnt - base), 64'd4);

        // Test 5: illegal commands
        base = rd_cnt;
        e0 = err_cnt;
        do_start(2'd0, 2'd0, 2'd1);
        check_eq("t5_err_n0", 64'(err_o), 64'd1);
        check_eq("t5_busy_n0", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        check_eq("t5_err_pulse", 64'(err_o), 64'd0);
        do_start(2'd0, 2'd1, 2'd3);
        check_eq("t5_err_k3", 64'(err_o), 64'd1);
        check_eq("t5_busy_k3", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        check_eq("t5_err_pulse2", 64'(err_o), 64'd0);
        check_eq("t5_valid", 64'(elem_valid_o), 64'd0);
        check_eq("t5_reads", 64'(rd_cnt - base), 64'd0);
        check_eq("t5_err_count", 64'(err_cnt - e0), 64'd2);

        // Test 6: reset after the second read, then a 2x1 read from slot 0
        base = rd_cnt;
        dc = done_cnt;
        do_start(2'd1, 2'd2, 2'd2);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i); #1;
            if (rd_cnt - base >= 2) seen = 1'b1;
        end
        check_eq("t6_two_reads", 64'(seen), 64'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check_all_zero();
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("t6_no_done", 64'(done_cnt - dc), 64'd0);
        check_eq("t6_idle", 64'(busy_o), 64'd0);
        base = rd_cnt;
        do_start(2'd0, 2'd2, 2'd1);
        wait_done();
        check_eq("t6_reads", 64'(rd_cnt - base), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sp_reader.md
Name: sp_reader

Overview:
- Read-side sequencer for the result scratchpad. On a start command it walks one stored result matrix (selected SP target, n rows × k cols) in row-major order and drives scratchpad read addresses.
- It captures each returned element and presents it on a valid/ready element stream with row/col tags and a last flag.
- It sits between the scratchpad and the bus-facing readout logic. It is the consumer of the matrices the scratchpad writer stores.

Parameters:
- SP_NTARGETS, 4: number of addressable matrix slots in the scratchpad.
- DATA_WIDTH, 32: operand width; one scratchpad element is 2*DATA_WIDTH bits.
- BUS_WIDTH, 64: bus width.
- ADDR_WIDTH, 32: scratchpad address width.
- Derived (localparam) MAX_DIM = BUS_WIDTH/DATA_WIDTH: maximum matrix dimension.
- Derived (localparam) SPN_W = max(1,$clog2(SP_NTARGETS)).
- Derived (localparam) DIM_W = $clog2(MAX_DIM)+1.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start command, sampled only in IDLE.
- sp_number_i  in  SPN_W  SP target to read.
- n_dim_i  in  DIM_W  rows, legal 1..MAX_DIM.
- k_dim_i  in  DIM_W  cols, legal 1..MAX_DIM.
- sp_write_busy_i  in  1  scratchpad being written; reads forbidden this cycle.
- sp_rd_en_o  out  1  read strobe; sp_data_i is valid in the same cycle.
- sp_addr_o  out  ADDR_WIDTH  scratchpad read address.
- sp_data_i  in  2*DATA_WIDTH  scratchpad read data (combinational from sp_addr_o).
- elem_valid_o  out  1  output element valid.
- elem_ready_i  in  1  downstream accept.
- elem_data_o  out  2*DATA_WIDTH  element value.
- elem_row_o  out  DIM_W  element row index.
- elem_col_o  out  DIM_W  element column index.
- elem_last_o  out  1  final element of the matrix.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle illegal-command pulse.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE and the buffer is flushed.
  - All outputs are 0, including sp_addr_o and elem_data_o.
  - Reset mid-operation abandons the transfer silently: no done_o, no err_o.
- Address: sp_addr_o = sp_number*MAX_DIM*MAX_DIM + row*MAX_DIM + col, zero-extended to ADDR_WIDTH. Row stride is MAX_DIM regardless of k.
- sp_addr_o is 0 whenever sp_rd_en_o = 0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start_i=1 with all three of the following latches the command, clears row/col, and enters READ next cycle:
    - n_dim_i in 1..MAX_DIM;
    - k_dim_i in 1..MAX_DIM;
    - sp_number_i < SP_NTARGETS.
  - Any other start_i=1 pulses err_o for 1 cycle and stays in IDLE, with no read issued.
- start_i outside IDLE is ignored.
- READ:
  - A read issues in a cycle when sp_write_busy_i=0 and the buffer has space. Space means count<2, or count=2 with a pop in the same cycle.
  - On a read: sp_rd_en_o=1 and sp_data_i is pushed with its row/col tags at the clock edge.
  - col increments. At col=k-1, col wraps to 0 and row increments.
  - After the read of (n-1,k-1), go to DRAIN.
  - At most one read per cycle.
- Buffer: 2-entry FIFO, so full throughput is 1 element/cycle.
  - Pop happens on elem_valid_o & elem_ready_i.
  - Simultaneous push and pop is legal at every count.
  - While elem_valid_o=1 and elem_ready_i=0, elem_data_o, elem_row_o, elem_col_o and elem_last_o hold stable.
- elem_last_o=1 only with the element tagged (n-1,k-1).
- Latency: an element read in cycle t is visible on elem_valid_o in cycle t+1 at the earliest.
- DRAIN: wait until the FIFO is empty, i.e. the last element has been accepted, then go to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE. A new start is accepted from the following cycle.
- busy_o=1 in READ, DRAIN and DONE.
- sp_write_busy_i stalls reads only. Already-buffered elements keep draining.

Test Plan:
(MAX_DIM=2, SP_NTARGETS=4, elem_ready_i=1 unless stated)
1. start, sp=1, n=2, k=2 → sp_addr_o 4,5,6,7 on 4 consecutive sp_rd_en_o cycles. Elements tagged (0,0),(0,1),(1,0),(1,1) arrive one cycle later. elem_last_o is set only on (1,1). done_o pulses 2 cycles after the last acceptance. busy_o falls with it.
2. start, sp=3, n=1, k=2 → addresses 12,13 only. Last on (0,1). Exactly 2 elements.
3. As test 1 but elem_ready_i=0 throughout → exactly 2 reads (addr 4,5), then sp_rd_en_o=0. Element (0,0) is held stable. Raising ready resumes with addr 6 and order is preserved.
4. sp_write_busy_i=1 for 3 cycles after the first read → no sp_rd_en_o in those cycles. Reads resume at addr 5 and the output sequence is unchanged.
5. start with n=0, then k=3 → err_o 1-cycle pulse each time. busy_o=0, no reads, elem_valid_o=0.
6. Assert rst_i after the 2nd read → all outputs 0 asynchronously, no done_o. Then start sp=0, n=2, k=1 → addresses 0,2.
